mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the pipelined RISC-V core. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Drives a request/acknowledge data-memory bus, with byte lanes for SB/SH/SW and alignment plus sign/zero extension for LB/LH/LW/LBU/LHU.
- Stalls upstream stages while an access is outstanding.
- Produces the registered ReadData/ALU_result/control bundle consumed by MEM/WB.

Parameters:
- DATA_W, 32, data/address width (fixed at 32; only 32 is supported).
- TIMEOUT_CYCLES, 16, maximum cycles with mem_req high and no ack before the bus-error abort.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- ex_valid  in  1  EX/MEM holds a valid instruction.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_mem_to_reg  in  1  writeback selects memory data.
- ex_rd  in  5  destination register.
- ex_alu_result  in  32  effective address / ALU result.
- ex_store_data  in  32  rs2 value.
- ex_funct3  in  3  access size/sign.
- stall  out  1  hold EX/MEM and earlier stages.
- mem_req  out  1  bus request.
- mem_we  out  1  write enable.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  one-cycle completion pulse.
- mem_rdata  in  32  read word, valid with mem_ack.
- wb_valid  out  1  bundle valid (MEM/WB enable).
- wb_mem_read  out  1  registered copy of the input control.
- wb_mem_write  out  1  registered copy of the input control.
- wb_mem_to_reg  out  1  registered copy of the input control.
- wb_rd  out  5  registered copy.
- wb_read_data  out  32  aligned, extended load data.
- wb_alu_result  out  32  registered copy.
- wb_err  out  2  00 ok, 01 misaligned, 10 bus timeout.

Behaviour:
- Reset (reset==0 at a rising edge): state IDLE, counter 0, every registered output 0 (mem_req, mem_we, mem_addr, mem_wdata, mem_be, wb_*). stall is 0 while in reset.
- A reset arriving during BUSY abandons the access: mem_req is low after that edge and no wb_valid is produced.
- FSM states: IDLE, BUSY.
- IDLE, no memory op (ex_valid and neither read nor write):
  - Pass-through with 1-cycle latency: wb_valid=1 next cycle, wb_read_data=0, wb_err=00.
  - stall=0.
- IDLE, ex_valid=0: wb_valid=0 next cycle; other wb_* outputs hold.
- IDLE, memory op, misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0):
  - No bus request is issued.
  - Next cycle: wb_valid=1, wb_err=01, wb_read_data=0, wb_mem_write forced 0, wb_mem_to_reg forced 0.
  - stall=0.
- IDLE, memory op, aligned:
  - stall=1 combinationally in this cycle.
  - Next edge: state BUSY; mem_req=1; mem_we=ex_mem_write; address, wdata and be registered; counter=0.
- ex_mem_read and ex_mem_write both high: treated as a store.
- Store lanes:
  - SB: wdata={4{byte}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{half}}, be=4'b0011<<{addr[1],1'b0}.
  - SW: wdata=data, be=4'b1111.
- Loads drive be=4'b1111.
- BUSY:
  - stall=1.
  - mem_* outputs held stable until ack.
  - counter increments each cycle without ack.
- mem_ack in BUSY:
  - Next edge: mem_req=0, state IDLE, wb_valid=1, wb_err=00, control/rd/alu_result registered from the EX/MEM inputs (still held by stall).
  - wb_read_data = mem_rdata >> (8*addr[1:0]), then extended per funct3: 000 sign byte, 001 sign half, 010 word, 100 zero byte, 101 zero half. For stores it is 0.
  - stall=0 in the ack cycle itself, so upstream advances on the same edge.
- Timeout: counter reaches TIMEOUT_CYCLES-1 with no ack → next edge: mem_req=0, IDLE, wb_valid=1, wb_err=10, wb_read_data=0, wb_mem_to_reg=0, wb_mem_write=0.
- Ack on the timeout cycle: ack wins.
- mem_ack while IDLE: ignored.
- Minimum memory-op latency: 2 cycles (request cycle + ack cycle), wb_valid on the following edge.
- Back-to-back memory ops: a new request may start on the edge after wb_valid; there is no overlap.

Decomposition:
- Shared package (riscv_pkg): funct3 load/store encodings (LB/LH/LW/LBU/LHU/SB/SH/SW), the wb_err codes, and the FSM state encoding.
- One sub-module, lsu_align: purely combinational. Computes the store lane/byte-enable, the load shift/extend, and the misalignment check.
- The FSM, timeout counter and output registers live in mem_access_stage.

Test Plan:
- Reset low for 2 cycles mid-BUSY (SW pending) → mem_req=0 after the edge, all wb_*=0, no wb_valid after release.
- ALU op rd=5, alu_result=0x1234 → wb_valid=1 one cycle later, wb_alu_result=0x1234, wb_rd=5, stall never high.
- LB addr=0x103, ack after 3 cycles with rdata=0x80FF_0000 → stall high 4 cycles (IDLE cycle + 3 BUSY cycles), mem_addr=0x100, wb_read_data=0xFFFF_FF80; LBU same → 0x0000_0080.
- SH addr=0x202, data=0xABCD_1234 → mem_wdata=0x1234_1234, mem_be=4'b1100, mem_we=1; wb_err=00 after ack.
- LW addr=0x101 → no mem_req, wb_err=01, wb_mem_to_reg=0, stall=0.
- LW with ack never asserted (TIMEOUT_CYCLES=16) → mem_req high exactly 16 cycles, then wb_err=10, wb_read_data=0. Repeat with ack on the 16th cycle → wb_err=00.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the pipelined RISC-V core: funct3 access encodings,
// writeback error codes and the MEM-stage FSM states.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // funct3[1:0] carries the access size for both loads and stores
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ERR_OK         = 2'b00,
    ERR_MISALIGNED = 2'b01,
    ERR_TIMEOUT    = 2'b10
  } wb_err_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational load/store alignment: store lane replication and byte enables,
// load shift plus sign/zero extension, and the natural-alignment check.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misaligned,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    // NOTE: every output of this block is given a default first so no latch is inferred.
    wdata      = store_data;
    be         = 4'b1111;
    misaligned = 1'b0;
    unique case (funct3[1:0])
      SIZE_BYTE: begin
        wdata = {4{store_data[7:0]}};
        if (is_store) be = 4'b0001 << offset;
      end
      SIZE_HALF: begin
        wdata      = {2{store_data[15:0]}};
        misaligned = offset[0];
        if (is_store) be = 4'b0011 << {offset[1], 1'b0};
      end
      SIZE_WORD: misaligned = (offset != 2'b00);
      default: ;
    endcase
  end

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    load_data = shifted;
    case (funct3)
      F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  load_data = {24'h0, shifted[7:0]};
      F3_LHU:  load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the req/ack data bus, stalls upstream while an
// access is outstanding, and registers the bundle consumed by MEM/WB.
module mem_access_stage
  import riscv_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic [4:0]        ex_rd,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [2:0]        ex_funct3,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              wb_mem_read,
  output logic              wb_mem_write,
  output logic              wb_mem_to_reg,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [1:0]        wb_err
);

  mem_state_e        state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              mem_op, is_store, misaligned;
  logic              start, done_ok, done_to, stall_c;
  logic [DATA_W-1:0] lane_wdata, load_data;
  logic [3:0]        lane_be;

  assign mem_op   = ex_valid & (ex_mem_read | ex_mem_write);
  assign is_store = ex_mem_write;  // read+write together behaves as a store

  lsu_align u_align (
    .offset     (ex_alu_result[1:0]),
    .funct3     (ex_funct3),
    .is_store   (is_store),
    .store_data (ex_store_data),
    .rdata      (mem_rdata),
    .wdata      (lane_wdata),
    .be         (lane_be),
    .misaligned (misaligned),
    .load_data  (load_data)
  );

  always_comb begin
    state_next = state;
    stall_c    = 1'b0;
    start      = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_op && !misaligned) begin
          start      = 1'b1;
          stall_c    = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // The abort cycle releases stall like an ack, so the faulting
        // instruction retires instead of being reissued.
        if (mem_ack) begin
          done_ok    = 1'b1;
          state_next = ST_IDLE;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          done_to    = 1'b1;
          state_next = ST_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign stall = stall_c & reset;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt           <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= '0;
      wb_valid      <= 1'b0;
      wb_mem_read   <= 1'b0;
      wb_mem_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_rd         <= '0;
      wb_read_data  <= '0;
      wb_alu_result <= '0;
      wb_err        <= ERR_OK;
    end else if (state == ST_IDLE) begin
      if (start) begin
        mem_req   <= 1'b1;
        mem_we    <= is_store;
        mem_addr  <= {ex_alu_result[DATA_W-1:2], 2'b00};
        mem_wdata <= lane_wdata;
        mem_be    <= lane_be;
        cnt       <= '0;
        wb_valid  <= 1'b0;
      end else if (ex_valid) begin
        wb_valid      <= 1'b1;
        wb_mem_read   <= ex_mem_read;
        wb_rd         <= ex_rd;
        wb_alu_result <= ex_alu_result;
        wb_read_data  <= '0;
        if (mem_op) begin
          wb_mem_write  <= 1'b0;
          wb_mem_to_reg <= 1'b0;
          wb_err        <= ERR_MISALIGNED;
        end else begin
          wb_mem_write  <= ex_mem_write;
          wb_mem_to_reg <= ex_mem_to_reg;
          wb_err        <= ERR_OK;
        end
      end else begin
        wb_valid <= 1'b0;
      end
    end else begin
      if (done_ok || done_to) begin
        mem_req       <= 1'b0;
        wb_valid      <= 1'b1;
        wb_mem_read   <= ex_mem_read;
        wb_rd         <= ex_rd;
        wb_alu_result <= ex_alu_result;
        if (done_ok) begin
          wb_mem_write  <= ex_mem_write;
          wb_mem_to_reg <= ex_mem_to_reg;
          wb_read_data  <= is_store ? '0 : load_data;
          wb_err        <= ERR_OK;
        end else begin
          wb_mem_write  <= 1'b0;
          wb_mem_to_reg <= 1'b0;
          wb_read_data  <= '0;
          wb_err        <= ERR_TIMEOUT;
        end
      end else begin
        cnt      <= cnt + 1'b1;
        wb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized
// instructions compared against a transaction-level reference model.
module tb_mem_access_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [2:0]  ex_funct3;
  logic        stall, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, wb_mem_read, wb_mem_write, wb_mem_to_reg;
  logic [4:0]  wb_rd;
  logic [31:0] wb_read_data, wb_alu_result;
  logic [1:0]  wb_err;

  mem_access_stage #(.DATA_W(32), .TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_rd         (ex_rd),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_funct3     (ex_funct3),
    .stall         (stall),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .wb_valid      (wb_valid),
    .wb_mem_read   (wb_mem_read),
    .wb_mem_write  (wb_mem_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_rd         (wb_rd),
    .wb_read_data  (wb_read_data),
    .wb_alu_result (wb_alu_result),
    .wb_err        (wb_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the last retired writeback bundle
  logic        h_mr, h_mw, h_tr;
  logic [4:0]  h_rd;
  logic [31:0] h_data, h_alu;
  logic [1:0]  h_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] word, input int off,
                                           input logic [2:0] f3);
    logic [31:0] v;
    v = word >> (8 * off);
    case (f3[1:0])
      2'd0: begin
        v = v % 256;
        if (!f3[2] && v >= 128) v = v - 256;
      end
      2'd1: begin
        v = v % 65536;
        if (!f3[2] && v >= 32768) v = v - 65536;
      end
      default: ;
    endcase
    return v;
  endfunction

  task automatic clear_model();
    h_mr = 0; h_mw = 0; h_tr = 0; h_rd = 0; h_data = 0; h_alu = 0; h_err = 0;
  endtask

  task automatic check_wb(input logic exp_valid);
    check("wb_valid",      32'(wb_valid),      32'(exp_valid));
    check("wb_rd",         32'(wb_rd),         32'(h_rd));
    check("wb_alu_result", wb_alu_result,      h_alu);
    check("wb_read_data",  wb_read_data,       h_data);
    check("wb_err",        32'(wb_err),        32'(h_err));
    check("wb_mem_read",   32'(wb_mem_read),   32'(h_mr));
    check("wb_mem_write",  32'(wb_mem_write),  32'(h_mw));
    check("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(h_tr));
  endtask

  // One instruction through the stage. ack_wait = BUSY cycles without ack
  // before the ack cycle; ack_wait >= TO means the bus never answers.
  // Entered and left at posedge+1.
  task automatic do_op(input logic v, input logic rf, input logic wf, input logic tr,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [2:0] f3, input int ack_wait, input logic [31:0] rdata);
    logic        is_mem, mis, go;
    int          size, off, stall_hi, req_hi;
    logic [31:0] exp_be, exp_wd;
    is_mem = v && (rf || wf);
    size   = 1 << f3[1:0];
    off    = int'(alu[1:0]);
    mis    = is_mem && ((alu % size) != 0);
    go     = is_mem && !mis;
    exp_be = wf ? (((1 << size) - 1) << off) : 15;
    exp_wd = (size == 1) ? (sd % 256) * 32'h0101_0101 :
             (size == 2) ? (sd % 65536) * 32'h0001_0001 : sd;

    ex_valid = v; ex_mem_read = rf; ex_mem_write = wf; ex_mem_to_reg = tr;
    ex_rd = rd; ex_alu_result = alu; ex_store_data = sd; ex_funct3 = f3;
    mem_ack   = go ? 1'b0 : 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    check("stall_first", 32'(stall), 32'(go));
    stall_hi = int'(stall);
    req_hi   = 0;
    if (go) begin
      @(posedge clk); #1;
      check("mem_we",   32'(mem_we), 32'(wf));
      check("mem_addr", mem_addr, alu - off);
      check("mem_be",   32'(mem_be), exp_be);
      if (wf) check("mem_wdata", mem_wdata, exp_wd);
      for (int k = 0; k < TO; k++) begin
        mem_ack   = (k == ack_wait);
        mem_rdata = (k == ack_wait) ? rdata : $urandom;
        #1;
        req_hi   += int'(mem_req);
        stall_hi += int'(stall);
        if (k == ack_wait || k == TO - 1) break;
        @(posedge clk); #1;
      end
      check("mem_addr_hold", mem_addr, alu - off);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;

    if (v) begin
      h_rd = rd; h_alu = alu; h_mr = rf;
      if (!is_mem) begin
        h_mw = wf; h_tr = tr; h_data = 0; h_err = 0;
      end else if (mis) begin
        h_mw = 0; h_tr = 0; h_data = 0; h_err = 1;
      end else if (ack_wait < TO) begin
        h_mw = wf; h_tr = tr; h_err = 0;
        h_data = wf ? 32'h0 : ref_load(rdata, off, f3);
      end else begin
        h_mw = 0; h_tr = 0; h_data = 0; h_err = 2;
      end
    end
    check_wb(v);
    check("mem_req_after", 32'(mem_req), 0);
    if (go) begin
      if (ack_wait < TO) check("stall_cycles", stall_hi, 1 + ack_wait);
      else               check("req_cycles", req_hi, TO);
    end
  endtask

  initial begin
    logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  st_f3 [3] = '{3'b000, 3'b001, 3'b010};
    logic        v, rf, wf;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          kind, size, aw, r;

    reset = 0; ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0;
    ex_rd = 0; ex_alu_result = 0; ex_store_data = 0; ex_funct3 = 0;
    mem_ack = 0; mem_rdata = 0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall",     32'(stall),     0);
    check("rst_mem_req",   32'(mem_req),   0);
    check("rst_mem_we",    32'(mem_we),    0);
    check("rst_mem_addr",  mem_addr,       0);
    check("rst_mem_wdata", mem_wdata,      0);
    check("rst_mem_be",    32'(mem_be),    0);
    check_wb(1'b0);
    reset = 1;

    // Directed cases
    do_op(1, 0, 0, 0, 5'd5, 32'h1234, 32'h0, 3'b000, 0, 0);              // ALU
    do_op(1, 1, 0, 1, 5'd7, 32'h103, 32'h0, 3'b000, 3, 32'h80FF_0000);    // LB
    do_op(1, 1, 0, 1, 5'd8, 32'h103, 32'h0, 3'b100, 3, 32'h80FF_0000);    // LBU
    do_op(1, 0, 1, 0, 5'd0, 32'h202, 32'hABCD_1234, 3'b001, 1, 32'h0);    // SH
    do_op(1, 1, 0, 1, 5'd9, 32'h101, 32'h0, 3'b010, 0, 32'h0);            // LW misaligned
    do_op(1, 1, 0, 1, 5'd10, 32'h400, 32'h0, 3'b010, 100, 32'hDEAD_BEEF); // LW timeout
    do_op(1, 1, 0, 1, 5'd11, 32'h404, 32'h0, 3'b010, TO - 1, 32'hCAFE_F00D); // ack on last cycle
    do_op(0, 1, 0, 1, 5'd12, 32'h500, 32'h0, 3'b010, 0, 32'h0);           // bubble
    do_op(1, 1, 1, 0, 5'd13, 32'h603, 32'h0000_00A5, 3'b000, 0, 32'h0);   // read+write = store

    // Reset while an SW is outstanding
    ex_valid = 1; ex_mem_read = 0; ex_mem_write = 1; ex_mem_to_reg = 0;
    ex_rd = 5'd14; ex_alu_result = 32'h300; ex_store_data = 32'h55; ex_funct3 = 3'b010;
    mem_ack = 0;
    @(posedge clk); #1;
    check("busy_mem_req", 32'(mem_req), 1);
    @(posedge clk); #1;
    reset = 0;
    #1;
    check("stall_in_reset", 32'(stall), 0);
    @(posedge clk); #1;
    clear_model();
    check("abort_mem_req", 32'(mem_req), 0);
    check("abort_mem_be",  32'(mem_be),  0);
    check("abort_stall",   32'(stall),   0);
    check_wb(1'b0);
    @(posedge clk); #1;
    reset = 1; ex_valid = 0;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_wb_valid", 32'(wb_valid), 0);
      check("post_rst_mem_req",  32'(mem_req),  0);
    end

    // Randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      v    = ($urandom_range(0, 9) != 0);
      kind = $urandom_range(0, 3);
      rf   = (kind == 1 || kind == 3);
      wf   = (kind == 2 || kind == 3);
      f3   = wf ? st_f3[$urandom_range(0, 2)] : (rf ? ld_f3[$urandom_range(0, 4)] : 3'($urandom));
      size = 1 << f3[1:0];
      addr = $urandom;
      if ($urandom_range(0, 2) != 0 && size <= 4) addr = addr - (addr % size);
      r  = $urandom_range(0, 9);
      aw = (r < 7) ? $urandom_range(0, 4) : (r == 7) ? $urandom_range(TO - 2, TO - 1) : 40;
      do_op(v, rf, wf, 1'($urandom_range(0, 1)), 5'($urandom), addr, $urandom, f3, aw, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
